// File: rtl/pueo_leveltwo_gen2.sv
// Level-two trigger former: masked per-TIO L1 bits -> per-polarity L2/LF/aux -> gated master trigger.
// Latency: trig_i captured on ce edge k gives trig_o on ce edge k+1 (one clk wide); meta_o delayed META_DELAY ce.
// Backpressure: none; requests that arrive during holdoff or dead are dropped and counted, never queued.
module pueo_leveltwo_gen2 #(
  parameter int NTIO         = 4,
  parameter int META_DELAY   = 1,
  parameter int HOLDOFF_BITS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic [8*NTIO-1:0]       trig_i,
  input  logic [64*NTIO-1:0]      meta_i,
  input  logic [8*NTIO-1:0]       mask_i,
  input  logic                    run_i,
  input  logic                    dead_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_len_i,
  output logic                    trig_o,
  output logic [3:0]              trig_type_o,
  output logic [64*NTIO-1:0]      meta_o,
  output logic                    holdoff_o,
  output logic [31:0]             trig_count_o,
  output logic [15:0]             drop_count_o
);

  localparam int NHALF = NTIO / 2;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_HOLDOFF  = 2'd2;

  localparam logic [HOLDOFF_BITS-1:0] CNT_ONE  = {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};
  localparam logic [15:0]             DROP_MAX = 16'hFFFF;

  logic [8*NTIO-1:0]  w_masked;
  logic [1:0]         w_l2;
  logic [1:0]         w_lf;
  logic               w_aux;
  logic               w_q;
  logic               w_open;
  logic               w_fire;
  logic               w_drop;
  logic [64*NTIO-1:0] w_tap;

  logic [1:0]              r_l2;
  logic [1:0]              r_lf;
  logic                    r_aux;
  logic [64*NTIO-1:0]      r_dly [META_DELAY];
  logic [1:0]              r_state;
  logic [HOLDOFF_BITS-1:0] r_cnt;
  logic                    r_trig;
  logic [3:0]              r_type;
  logic [64*NTIO-1:0]      r_meta;
  logic [31:0]             r_trig_count;
  logic [15:0]             r_drop_count;

  assign w_masked = trig_i & ~mask_i;

  // Reduce the masked per-TIO bits into per-polarity L2/LF and a global aux.
  always_comb begin
    w_l2  = 2'b00;
    w_lf  = 2'b00;
    w_aux = 1'b0;
    for (int t = 0; t < NTIO; t++) begin
      if (t < NHALF) begin
        w_l2[0] = w_l2[0] | (|w_masked[8*t +: 6]);
        w_lf[0] = w_lf[0] | w_masked[8*t + 6];
      end else begin
        w_l2[1] = w_l2[1] | (|w_masked[8*t +: 6]);
        w_lf[1] = w_lf[1] | w_masked[8*t + 6];
      end
      w_aux = w_aux | w_masked[8*t + 7];
    end
  end

  // Stage-1 trigger register, advanced only on trigger-rate cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_l2  <= 2'b00;
      r_lf  <= 2'b00;
      r_aux <= 1'b0;
    end else if (ce_i) begin
      r_l2  <= w_l2;
      r_lf  <= w_lf;
      r_aux <= w_aux;
    end
  end

  // Metadata delay line; the whole bus shifts, so every TIO sees the same depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < META_DELAY; i++) r_dly[i] <= '0;
    end else if (ce_i) begin
      r_dly[0] <= meta_i;
      for (int i = 1; i < META_DELAY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_tap = r_dly[META_DELAY-1];
  assign w_q   = |{r_aux, r_lf, r_l2};

  // A holdoff whose counter has expired behaves as armed on that same ce,
  // which is what makes holdoff_len_i=N re-open exactly N+1 ce after a trigger.
  assign w_open = (r_state == ST_ARMED) ||
                  ((r_state == ST_HOLDOFF) && (r_cnt == '0));
  assign w_fire = ce_i && run_i && w_q && !dead_i && w_open;
  assign w_drop = ce_i && run_i && w_q && !w_fire &&
                  ((r_state == ST_ARMED) || (r_state == ST_HOLDOFF));

  // Arm/holdoff state machine and holdoff counter; run_i=0 overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_DISABLED;
      r_cnt   <= '0;
    end else if (!run_i) begin
      r_state <= ST_DISABLED;
      r_cnt   <= '0;
    end else if (ce_i) begin
      if (w_fire) begin
        r_state <= ST_HOLDOFF;
        r_cnt   <= holdoff_len_i;
      end else begin
        case (r_state)
          ST_DISABLED: r_state <= ST_ARMED;
          ST_ARMED:    r_state <= ST_ARMED;
          ST_HOLDOFF: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else if (!dead_i) begin
              r_state <= ST_ARMED;
            end
          end
          default: r_state <= ST_DISABLED;
        endcase
      end
    end
  end

  // Master trigger pulse plus the type/metadata snapshot held until the next trigger.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trig <= 1'b0;
      r_type <= 4'b0000;
      r_meta <= '0;
    end else begin
      r_trig <= w_fire;
      if (w_fire) begin
        r_type <= {r_aux, |r_lf, r_l2[1], r_l2[0]};
        r_meta <= w_tap;
      end
    end
  end

  // Issued-trigger counter (wraps) and dropped-request counter (saturates).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trig_count <= 32'd0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_fire) r_trig_count <= r_trig_count + 32'd1;
      if (w_drop && (r_drop_count != DROP_MAX)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign trig_o       = r_trig;
  assign trig_type_o  = r_type;
  assign meta_o       = r_meta;
  assign holdoff_o    = (r_state == ST_HOLDOFF);
  assign trig_count_o = r_trig_count;
  assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_pueo_leveltwo_gen2.sv
// Bench for pueo_leveltwo_gen2: two instances (META_DELAY 1 and 4) share stimulus.
// Latency: expected triggers queued at stimulus time, popped by a monitor on trig_o.
// Backpressure: none.
module tb_pueo_leveltwo_gen2;
  localparam int NTIO = 4;
  localparam int MW   = 64*NTIO;

  logic          clk = 1'b0;
  logic          rst_i, ce_i, run_i, dead_i;
  logic [8*NTIO-1:0] trig_i, mask_i;
  logic [MW-1:0] meta_i;
  logic [15:0]   holdoff_len_i;

  logic          trig1, trig4, hold1, hold4;
  logic [3:0]    type1, type4;
  logic [MW-1:0] meta1, meta4;
  logic [31:0]   tcnt1, tcnt4;
  logic [15:0]   dcnt1, dcnt4;

  typedef struct {
    logic [3:0]    typ;
    logic [MW-1:0] m1;
    logic [MW-1:0] m4;
    logic [31:0]   cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  int checks = 0;
  int errors = 0;
  int ce_n   = 0;
  int k0;

  always #5 clk = ~clk;

  pueo_leveltwo_gen2 #(.NTIO(NTIO), .META_DELAY(1), .HOLDOFF_BITS(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .ce_i(ce_i), .trig_i(trig_i), .meta_i(meta_i),
    .mask_i(mask_i), .run_i(run_i), .dead_i(dead_i), .holdoff_len_i(holdoff_len_i),
    .trig_o(trig1), .trig_type_o(type1), .meta_o(meta1), .holdoff_o(hold1),
    .trig_count_o(tcnt1), .drop_count_o(dcnt1)
  );

  pueo_leveltwo_gen2 #(.NTIO(NTIO), .META_DELAY(4), .HOLDOFF_BITS(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .ce_i(ce_i), .trig_i(trig_i), .meta_i(meta_i),
    .mask_i(mask_i), .run_i(run_i), .dead_i(dead_i), .holdoff_len_i(holdoff_len_i),
    .trig_o(trig4), .trig_type_o(type4), .meta_o(meta4), .holdoff_o(hold4),
    .trig_count_o(tcnt4), .drop_count_o(dcnt4)
  );

  function automatic logic [MW-1:0] pat(input int n);
    logic [MW-1:0] v;
    v = '0;
    for (int t = 0; t < NTIO; t++) v[64*t +: 64] = {16'hC0DE, 8'(t), 8'(n), 32'(n*7 + t + 1)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k is the ce index at which the trigger bits are captured by stage 1
  task automatic expect_trig(input logic [3:0] typ, input int k, input logic [31:0] cnt);
    exp_t e;
    e.typ = typ;
    e.m1  = pat(k);
    e.m4  = pat(k - 3);
    e.cnt = cnt;
    q1.push_back(e);
    q4.push_back(e);
  endtask

  // one ce edge followed by one idle clk (ce every 2 clk)
  task automatic ce_pulse();
    meta_i = pat(ce_n);
    ce_i   = 1'b1;
    @(posedge clk); #1;
    ce_n++;
    ce_i   = 1'b0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every trig_o pulse is matched against the queued expectation.
  always @(negedge clk) begin
    if (!rst_i && trig1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_trig_d1: got 1 expected 0");
      end else begin
        e1 = q1.pop_front();
        chk("type_d1", MW'(type1), MW'(e1.typ));
        chk("meta_d1", meta1, e1.m1);
        chk("tcnt_d1", MW'(tcnt1), MW'(e1.cnt));
      end
    end
    if (!rst_i && trig4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_trig_d4: got 1 expected 0");
      end else begin
        e4 = q4.pop_front();
        chk("type_d4", MW'(type4), MW'(e4.typ));
        chk("meta_d4", meta4, e4.m4);
        chk("tcnt_d4", MW'(tcnt4), MW'(e4.cnt));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; ce_i = 1'b0; run_i = 1'b0; dead_i = 1'b0;
    trig_i = '0; mask_i = '0; meta_i = '0; holdoff_len_i = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // reset state
    chk("rst_trig", MW'(trig1), MW'(1'b0));
    chk("rst_type", MW'(type1), MW'(4'd0));
    chk("rst_meta", meta1, '0);
    chk("rst_hold", MW'(hold1), MW'(1'b0));
    chk("rst_tcnt", MW'(tcnt1), MW'(32'd0));
    chk("rst_dcnt", MW'(dcnt1), MW'(16'd0));

    run_i = 1'b1;
    repeat (5) ce_pulse();
    chk("armed_idle_tcnt", MW'(tcnt1), MW'(32'd0));

    // basic: TIO1 bit3
    trig_i[8+3] = 1'b1; expect_trig(4'b0001, ce_n, 32'd1); ce_pulse();
    trig_i = '0; ce_pulse();
    chk("basic_tcnt", MW'(tcnt1), MW'(32'd1));
    chk("basic_hold_hi", MW'(hold1), MW'(1'b1));
    ce_pulse();
    chk("basic_hold_lo", MW'(hold1), MW'(1'b0));

    // TIO2 bit6: polarity-1 LF
    trig_i[16+6] = 1'b1; expect_trig(4'b0100, ce_n, 32'd2); ce_pulse();
    trig_i = '0; ce_pulse(); ce_pulse();

    // TIO3 bit5 masked
    mask_i[29] = 1'b1; trig_i[29] = 1'b1;
    repeat (3) ce_pulse();
    trig_i = '0; mask_i = '0; ce_pulse();
    chk("mask_tcnt", MW'(tcnt1), MW'(32'd2));
    chk("mask_dcnt", MW'(dcnt1), MW'(16'd0));

    // holdoff 3 with q on every ce
    holdoff_len_i = 16'd3; trig_i[0] = 1'b1; k0 = ce_n;
    expect_trig(4'b0001, k0, 32'd3);
    expect_trig(4'b0001, k0 + 4, 32'd4);
    repeat (5) ce_pulse();
    trig_i = '0; ce_pulse();
    chk("hold_dcnt", MW'(dcnt1), MW'(16'd3));
    chk("hold_tcnt", MW'(tcnt1), MW'(32'd4));
    repeat (3) ce_pulse();
    chk("hold_still", MW'(hold1), MW'(1'b1));
    ce_pulse();
    chk("hold_rearm", MW'(hold1), MW'(1'b0));

    // dead through holdoff expiry
    holdoff_len_i = 16'd2; trig_i[1] = 1'b1; expect_trig(4'b0001, ce_n, 32'd5); ce_pulse();
    trig_i = '0; ce_pulse();
    dead_i = 1'b1;
    repeat (4) ce_pulse();
    chk("dead_hold", MW'(hold1), MW'(1'b1));
    dead_i = 1'b0; ce_pulse();
    chk("dead_rearm", MW'(hold1), MW'(1'b0));
    dead_i = 1'b1; trig_i[31] = 1'b1; ce_pulse();
    trig_i = '0; ce_pulse();
    chk("dead_drop", MW'(dcnt1), MW'(16'd4));
    chk("dead_tcnt", MW'(tcnt1), MW'(32'd5));
    dead_i = 1'b0;
    trig_i[31] = 1'b1; expect_trig(4'b1000, ce_n, 32'd6); ce_pulse();
    trig_i = '0; ce_pulse();
    repeat (3) ce_pulse();
    chk("aux_rearm", MW'(hold1), MW'(1'b0));

    // back-to-back with holdoff 0
    holdoff_len_i = 16'd0; k0 = ce_n;
    trig_i[6] = 1'b1; trig_i[16+2] = 1'b1; expect_trig(4'b0110, k0, 32'd7); ce_pulse();
    trig_i = '0; trig_i[16] = 1'b1; expect_trig(4'b0010, k0 + 1, 32'd8); ce_pulse();
    expect_trig(4'b0010, k0 + 2, 32'd9); ce_pulse();
    trig_i = '0; ce_pulse(); ce_pulse();
    chk("b2b_tcnt", MW'(tcnt1), MW'(32'd9));
    chk("b2b_dcnt", MW'(dcnt1), MW'(16'd4));
    chk("b2b_hold", MW'(hold1), MW'(1'b0));

    // reset mid-holdoff
    holdoff_len_i = 16'd100; trig_i[0] = 1'b1; expect_trig(4'b0001, ce_n, 32'd10); ce_pulse();
    trig_i = '0; ce_pulse(); ce_pulse();
    chk("pre_rst_hold", MW'(hold1), MW'(1'b1));
    rst_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    chk("mid_rst_hold", MW'(hold1), MW'(1'b0));
    chk("mid_rst_tcnt", MW'(tcnt1), MW'(32'd0));
    chk("mid_rst_dcnt", MW'(dcnt1), MW'(16'd0));
    chk("mid_rst_type", MW'(type1), MW'(4'd0));
    chk("mid_rst_meta", meta1, '0);
    chk("mid_rst_meta4", meta4, '0);
    holdoff_len_i = 16'd1;
    repeat (5) ce_pulse();

    // q coinciding with run_i falling: neither trigger nor drop
    trig_i[0] = 1'b1; ce_pulse();
    trig_i = '0; run_i = 1'b0; ce_pulse(); ce_pulse();
    chk("disarm_tcnt", MW'(tcnt1), MW'(32'd0));
    chk("disarm_dcnt", MW'(dcnt1), MW'(16'd0));
    run_i = 1'b1; ce_pulse();
    trig_i[8] = 1'b1; expect_trig(4'b0001, ce_n, 32'd1); ce_pulse();
    trig_i = '0; ce_pulse();
    chk("rearm_tcnt", MW'(tcnt1), MW'(32'd1));
    repeat (2) ce_pulse();

    // drop counter saturation: dead with q on every clk
    dead_i = 1'b1; trig_i[0] = 1'b1; ce_i = 1'b1;
    repeat (66000) @(posedge clk);
    #1 ce_i = 1'b0; trig_i = '0;
    ce_pulse();
    chk("sat_dcnt", MW'(dcnt1), MW'(16'hFFFF));
    chk("sat_tcnt", MW'(tcnt1), MW'(32'd1));
    dead_i = 1'b0;
    repeat (2) ce_pulse();

    chk("q1_empty", MW'(q1.size()), '0);
    chk("q4_empty", MW'(q4.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pueo_leveltwo_gen2.md
# pueo_leveltwo_gen2

Second-generation level-two trigger former for the TURF. It collects per-TURFIO level-one trigger bits and forms per-polarity L2, LF and aux triggers under a per-bit mask, and issues a single master trigger pulse. A programmable holdoff state machine and trigger/drop counters are added. It carries a parametrised metadata delay line so that metadata emerges aligned with the trigger pulse. It sits between the TURFIO trigger receivers and the event/metadata builder.

## Interface
Parameters:
- NTIO, 4, number of TURFIO sources (even, 2..8); TIOs [0, NTIO/2) are polarity 0, [NTIO/2, NTIO) are polarity 1
- META_DELAY, 1, metadata delay in ce periods (1..8)
- HOLDOFF_BITS, 16, width of holdoff length/counter

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- ce_i  in  1  clock enable; marks the trigger-rate cycles
- trig_i  in  8*NTIO  per-TIO trigger bits, TIO n at [8n+7:8n]: bits 5:0 L2 sectors, bit 6 LF, bit 7 aux
- meta_i  in  64*NTIO  per-TIO metadata, TIO n at [64n+63:64n]
- mask_i  in  8*NTIO  1 = ignore corresponding trig_i bit
- run_i  in  1  arm enable
- dead_i  in  1  readout dead; blocks triggers
- holdoff_len_i  in  HOLDOFF_BITS  holdoff length in ce periods after each trigger
- trig_o  out  1  master trigger, one clk wide
- trig_type_o  out  4  {aux, lf, l2_pol1, l2_pol0} sources of the last trigger, valid with trig_o and held until the next trigger
- meta_o  out  64*NTIO  metadata aligned to trig_o, held until the next trigger
- holdoff_o  out  1  high while in HOLDOFF
- trig_count_o  out  32  issued triggers, wraps
- drop_count_o  out  16  qualified triggers suppressed by holdoff/dead, saturates at 0xFFFF

## Operation
- **Masking:** the masked input is m = trig_i & ~mask_i, evaluated every ce.
- **Stage 1** (registered on ce):
  - l2[p] = OR of m[5:0] over the TIOs of polarity p.
  - lf[p] = OR of m[6] over the TIOs of polarity p.
  - aux = OR of m[7] over all TIOs.
- **Qualified request:** q = any stage-1 bit set. It is evaluated on the next ce.
- **States:**
  - DISABLED:
    - Entered on reset, or whenever run_i=0; run_i=0 takes priority over everything.
    - Moves to ARMED on the first ce with run_i=1.
  - ARMED:
    - On a ce with q=1 and dead_i=0: trig_o=1 for one clk, latch trig_type_o = {aux, |lf, l2[1], l2[0]}, latch meta_o, increment trig_count_o, load counter with holdoff_len_i, go to HOLDOFF.
    - On a ce with q=1 and dead_i=1: increment drop_count_o and stay in ARMED.
  - HOLDOFF:
    - Each ce decrements the counter when it is nonzero.
    - Each ce with q=1 increments drop_count_o.
    - Moves to ARMED on a ce where the counter equals 0 and dead_i=0.
    - While dead_i=1 it stays in HOLDOFF with the counter at 0.
    - holdoff_len_i=0 gives re-arm on the next ce, so back-to-back triggers are possible on consecutive ce cycles.
- **Metadata delay:** a META_DELAY-deep ce-enabled shift register per TIO. meta_o latches the tap output at the trigger edge.
- **Ordering:** mask_i and holdoff_len_i changes take effect on the next ce. holdoff_len_i is sampled only at trigger.

## Timing
- **Reset values:** all outputs are 0 and all counters are 0.
  - Stage registers and the delay line are 0.
  - The state is DISABLED.
- **Reset mid-HOLDOFF:** returns to DISABLED with the counter cleared.
- **Trigger latency:**
  - trig_i sampled at ce edge k feeds stage 1.
  - trig_o rises at ce edge k+1 and falls at the next clk edge.
  - trig_o is never high on a clk where ce_i was 0 at that edge.
- **Metadata alignment:** meta_o at the trigger equals meta_i sampled META_DELAY ce edges before the trig_o edge. With META_DELAY=1, this is the meta_i of ce edge k.
- **holdoff_o:** rises with trig_o and falls on the edge entering ARMED.
- **Holdoff length:** holdoff_len_i=N means the earliest next trigger is N+1 ce periods after the previous one (provided dead_i=0).
- **Simultaneous events:**
  - q with run_i 1→0 on the same ce: no trigger, no drop count.
  - q with dead_i=1: a drop, not a trigger.
- **Counter overflow:** trig_count_o wraps at 2^32; drop_count_o saturates.

## Test plan
- **Basic trigger:** reset, run_i=1, ce every 2 clk, TIO1 trig bit 3 set for one ce → exactly one trig_o pulse one ce later, trig_type_o=4'b0001, trig_count_o=1, meta_o equal to TIO1 meta from that ce.
- **Polarity, type and mask:** TIO2 bit6 → trig_type_o=4'b0100. TIO3 bit5 with mask_i bit29 set → no trigger and no drop.
- **Holdoff and drops:** holdoff_len_i=3, trigger at ce 0, q on every ce → triggers at ce 1 and ce 5, drop_count_o=3 after ce 5.
- **Dead behaviour:** dead_i=1 held through holdoff expiry → stays in HOLDOFF, holdoff_o=1; dead_i falls → re-arm on the next ce; q while ARMED and dead → drop_count_o increments.
- **Back-to-back triggers:** holdoff_len_i=0 → triggers on consecutive ce. META_DELAY=4 → meta_o matches meta_i from 4 ce edges earlier.
- **Reset and disarm:** rst_i mid-HOLDOFF → all outputs 0, state DISABLED. run_i=0 then 1 → re-arms on the next ce. Preset drop_count_o to 0xFFFF → stays 0xFFFF.
